iter_mult: RTL and testbench

Parametrised, iterative, handshake-driven multiplier. It is the sequential successor of the team's flat combinational 128×128 multiplier. Each cycle it consumes DIGIT bits of operand b and accumulates one shifted partial product into a 2·WIDTH-bit register, so the block trades latency for area. It adds optional two's-complement mode and valid/ready flow control, and sits between operand-producing datapath stages and a result consumer that may apply backpressure.

---
 rtl/iter_mult.sv | 129 ++++++++++++
 tb/tb_iter_mult.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_mult.sv
// Iterative radix-2^DIGIT multiplier with valid/ready handshake on both sides.
// Define ITER_MULT_SIGNED_EN to compile in two's-complement support via i_is_signed.
module iter_mult #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic                 i_is_signed,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [2*WIDTH-1:0]   o_result,
    output logic                 o_busy
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned IterW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned PPW   = WIDTH + DIGIT;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             r_state, w_state_d;
    logic [WIDTH-1:0]   r_ma, w_ma_d;
    logic [WIDTH-1:0]   r_mb, w_mb_d;
    logic [PW-1:0]      r_acc, w_acc_d;
    logic [PW-1:0]      r_result, w_result_d;
    logic [IterW-1:0]   r_iter, w_iter_d;
    logic [PPW-1:0]     w_pp;
    logic [PW-1:0]      w_pp_ext;
    logic [PW-1:0]      w_acc_next;
    logic [PW-1:0]      w_final;
    logic [WIDTH-1:0]   w_op_a, w_op_b;
    logic               w_accept;

    assign w_accept = (r_state == StIdle) && i_in_valid;

    // r_mb is shifted right each iteration, so the current digit is always its low bits.
    assign w_pp       = PPW'(r_ma) * PPW'(r_mb[DIGIT-1:0]);
    assign w_pp_ext   = PW'(w_pp);
    assign w_acc_next = r_acc + (w_pp_ext << (32'(r_iter) * DIGIT));

`ifdef ITER_MULT_SIGNED_EN
    logic r_neg;

    // -x over WIDTH bits maps -2^(WIDTH-1) onto itself, which is the correct unsigned magnitude.
    assign w_op_a  = (i_is_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_op_b  = (i_is_signed && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_final = r_neg ? -w_acc_next : w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= i_is_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
        end
    end
`else
    logic w_unused_is_signed;

    assign w_unused_is_signed = i_is_signed;
    assign w_op_a             = i_a;
    assign w_op_b             = i_b;
    assign w_final            = w_acc_next;
`endif

    always_comb begin
        w_state_d  = r_state;
        w_ma_d     = r_ma;
        w_mb_d     = r_mb;
        w_acc_d    = r_acc;
        w_iter_d   = r_iter;
        w_result_d = r_result;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = StRun;
                    w_ma_d    = w_op_a;
                    w_mb_d    = w_op_b;
                    w_acc_d   = '0;
                    w_iter_d  = '0;
                end
            end
            StRun: begin
                w_acc_d  = w_acc_next;
                w_mb_d   = r_mb >> DIGIT;
                w_iter_d = r_iter + 1'b1;
                if (r_iter == IterW'(N - 1)) begin
                    w_state_d  = StDone;
                    w_result_d = w_final;
                end
            end
            StDone: begin
                if (i_out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_ma     <= '0;
            r_mb     <= '0;
            r_acc    <= '0;
            r_iter   <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_d;
            r_ma     <= w_ma_d;
            r_mb     <= w_mb_d;
            r_acc    <= w_acc_d;
            r_iter   <= w_iter_d;
            r_result <= w_result_d;
        end
    end

    assign o_in_ready  = (r_state == StIdle);
    assign o_out_valid = (r_state == StDone);
    assign o_busy      = (r_state != StIdle);
    assign o_result    = r_result;

endmodule

// File: tb/tb_iter_mult.sv
// Bench for iter_mult at WIDTH=8, DIGIT=2: fixed vectors, handshake corner cases, random ops.
module tb_iter_mult;

    localparam int unsigned W = 8;
    localparam int unsigned D = 2;
    localparam int unsigned LAT = W / D;

`ifdef ITER_MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_in_valid = 1'b0;
    logic           o_in_ready;
    logic [W-1:0]   i_a = '0;
    logic [W-1:0]   i_b = '0;
    logic           i_is_signed = 1'b0;
    logic           o_out_valid;
    logic           i_out_ready = 1'b0;
    logic [2*W-1:0] o_result;
    logic           o_busy;

    int checks = 0;
    int failures = 0;

    iter_mult #(.WIDTH(W), .DIGIT(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_is_signed (i_is_signed),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_result    (o_result),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Product by plain integer arithmetic on (optionally sign-extended) operands.
    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic s);
        longint x;
        longint y;
        if (s && SIGNED_EN) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        return 16'(x * y);
    endfunction

    // Present one operand pair for a single edge, then scramble inputs.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s);
        @(negedge clk);
        i_in_valid  = 1'b1;
        i_a         = a;
        i_b         = b;
        i_is_signed = s;
        @(posedge clk);
        #1;
        i_in_valid  = 1'b0;
        i_a         = 8'($urandom);
        i_b         = 8'($urandom);
        i_is_signed = ~s;
    endtask

    task automatic wait_valid(output int lat, output bit ready_bad);
        lat = 0;
        ready_bad = 1'b0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (o_in_ready || !o_busy) ready_bad = 1'b1;
        end while (!o_out_valid && lat < 20);
    endtask

    task automatic finish_op();
        @(negedge clk);
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        i_out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        bit bad;
        logic [7:0] ra, rb;
        logic rs;

        vecs[0] = '{8'd3,   8'd5,   1'b0, 16'h000F};
        vecs[1] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
        vecs[2] = '{8'hFD,  8'd5,   1'b0, 16'h04F1};
`ifdef ITER_MULT_SIGNED_EN
        vecs[3] = '{8'hFD,  8'd5,   1'b1, 16'hFFF1};
        vecs[4] = '{8'h80,  8'h80,  1'b1, 16'h4000};
        vecs[5] = '{8'h80,  8'h7F,  1'b1, 16'hC080};
`else
        vecs[3] = '{8'hFD,  8'd5,   1'b1, 16'h04F1};
        vecs[4] = '{8'h80,  8'h80,  1'b1, 16'h4000};
        vecs[5] = '{8'h80,  8'h7F,  1'b1, 16'h3F80};
`endif

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 16'(o_out_valid), 16'd0);
        check("reset_busy", 16'(o_busy), 16'd0);
        check("reset_result", o_result, 16'h0000);
        check("reset_in_ready", 16'(o_in_ready), 16'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].s);
            wait_valid(lat, bad);
            check($sformatf("vec%0d_latency", i), 16'(lat), 16'(LAT));
            check($sformatf("vec%0d_ready_low", i), 16'(bad), 16'd0);
            check($sformatf("vec%0d_result", i), o_result, vecs[i].exp);
            finish_op();
            check($sformatf("vec%0d_idle", i), 16'({o_out_valid, o_in_ready}), 16'b01);
        end

        // Backpressure: hold result for 5 cycles while a new pair is offered.
        start_op(8'h12, 8'h34, 1'b0);
        wait_valid(lat, bad);
        check("bp_latency", 16'(lat), 16'(LAT));
        check("bp_result", o_result, 16'h03A8);
        i_in_valid  = 1'b1;
        i_a         = 8'h0B;
        i_b         = 8'h0D;
        i_is_signed = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (!o_out_valid || o_in_ready || o_result !== 16'h03A8) bad = 1'b1;
        end
        check("bp_hold_stable", 16'(bad), 16'd0);
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        i_out_ready = 1'b0;
        check("bp_handshake_idle", 16'({o_out_valid, o_in_ready, o_busy}), 16'b010);
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        check("bp_next_accept", 16'({o_in_ready, o_busy}), 16'b01);
        wait_valid(lat, bad);
        check("bp_next_latency", 16'(lat), 16'(LAT));
        check("bp_next_result", o_result, 16'h008F);
        finish_op();

        // Reset two cycles into RUN discards the product.
        start_op(8'h55, 8'h66, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 16'({o_out_valid, o_busy, o_in_ready}), 16'b001);
        check("rst_mid_result", o_result, 16'h0000);
        i_in_valid = 1'b1;
        i_a = 8'h01;
        i_b = 8'h01;
        @(posedge clk);
        #1;
        check("rst_no_capture", 16'(o_busy), 16'd0);
        i_in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (o_out_valid || o_busy) bad = 1'b1;
        end
        check("rst_quiet_after", 16'(bad), 16'd0);
        start_op(8'd7, 8'd9, 1'b0);
        wait_valid(lat, bad);
        check("rst_fresh_latency", 16'(lat), 16'(LAT));
        check("rst_fresh_result", o_result, 16'h003F);
        finish_op();

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            start_op(ra, rb, rs);
            wait_valid(lat, bad);
            check($sformatf("rand%0d_latency", i), 16'(lat), 16'(LAT));
            check($sformatf("rand%0d_result a=%h b=%h s=%0d", i, ra, rb, rs), o_result,
                  ref_mul(ra, rb, rs));
            finish_op();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
